// File: rtl/complex_dot_acc.sv
// complex_dot_acc: accumulates LEN complex products, then presents the sum
// through a valid/ready hold stage. After each result handshake, inReady
// stays low for one extra cycle before the next dot product can start.
module complex_dot_acc #(
  parameter  int WIDTH     = 8,
  parameter  int LEN       = 4,
  localparam int ACC_WIDTH = 2*WIDTH + $clog2(LEN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        inValid,
  input  logic signed [2*WIDTH-1:0]   inReal,
  input  logic signed [2*WIDTH-1:0]   inImag,
  output logic                        inReady,
  output logic                        outValid,
  output logic signed [ACC_WIDTH-1:0] outReal,
  output logic signed [ACC_WIDTH-1:0] outImag,
  input  logic                        outReady
);

  localparam int CNT_W = $clog2(LEN);
  localparam int EXT_W = ACC_WIDTH - 2*WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e                       state_q;
  logic signed [ACC_WIDTH-1:0]  acc_re_q, acc_im_q;
  logic signed [ACC_WIDTH-1:0]  out_re_q, out_im_q;
  logic        [CNT_W-1:0]      cnt_q;
  logic                         out_valid_q;
  logic                         in_ready_q;

  logic signed [ACC_WIDTH-1:0]  in_re_ext, in_im_ext;
  logic signed [ACC_WIDTH-1:0]  sum_re_d, sum_im_d;

  // Sign-extend the incoming product and form the running sum with it.
  // The accumulator is wide enough that LEN full-scale products cannot wrap.
  always_comb begin
    in_re_ext = {{EXT_W{inReal[2*WIDTH-1]}}, inReal};
    in_im_ext = {{EXT_W{inImag[2*WIDTH-1]}}, inImag};
    sum_re_d  = acc_re_q + in_re_ext;
    sum_im_d  = acc_im_q + in_im_ext;
  end

  // Control FSM plus datapath registers. The handshake flags are kept as
  // registers so the ports come straight from flops. When in_ready_q is low
  // in ACCUM, that cycle is the bubble that follows a result handshake.
  // NOTE: every register here is written with <= so all of them update
  // together from the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      // Flush discards both the partial sum and any pending result. The
      // last result value stays on the output, but it is no longer valid.
      state_q     <= ACCUM;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ACCUM: begin
          if (!in_ready_q) begin
            in_ready_q <= 1'b1;
          end else if (inValid) begin
            if (cnt_q == LAST) begin
              out_re_q    <= sum_re_d;
              out_im_q    <= sum_im_d;
              acc_re_q    <= '0;
              acc_im_q    <= '0;
              cnt_q       <= '0;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              state_q     <= HOLD;
            end else begin
              acc_re_q <= sum_re_d;
              acc_im_q <= sum_im_d;
              cnt_q    <= cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          // in_ready_q stays low, which produces the one-cycle bubble.
          if (outReady) begin
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign inReady  = in_ready_q;
  assign outValid = out_valid_q;
  assign outReal  = out_re_q;
  assign outImag  = out_im_q;

endmodule

// File: tb/tb_complex_dot_acc.sv
// Testbench for complex_dot_acc (WIDTH=8, LEN=4). Directed scenarios plus
// random traffic, compared every cycle against a transaction-level model
// that keeps the accepted products in queues.
module tb_complex_dot_acc;

  localparam int W   = 8;
  localparam int L   = 4;
  localparam int ACW = 2*W + $clog2(L);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush = 1'b0;
  logic                  in_valid = 1'b0;
  logic signed [2*W-1:0] in_real = '0;
  logic signed [2*W-1:0] in_imag = '0;
  logic                  out_ready = 1'b0;
  logic                  in_ready;
  logic                  out_valid;
  logic signed [ACW-1:0] out_real;
  logic signed [ACW-1:0] out_imag;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: the products accepted so far, plus flags for a pending
  // result and for the bubble cycle.
  int  m_re_q[$];
  int  m_im_q[$];
  bit  m_hold;
  bit  m_bubble;
  int  m_out_re;
  int  m_out_im;

  complex_dot_acc #(.WIDTH(W), .LEN(L)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .inValid  (in_valid),
    .inReal   (in_real),
    .inImag   (in_imag),
    .inReady  (in_ready),
    .outValid (out_valid),
    .outReal  (out_real),
    .outImag  (out_imag),
    .outReady (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_re_q.delete();
    m_im_q.delete();
    m_hold   = 1'b0;
    m_bubble = 1'b0;
    m_out_re = 0;
    m_out_im = 0;
  endtask

  // One rising edge of behaviour, using the inputs as they are currently driven.
  task automatic model_tick();
    int sr, si;
    if (flush) begin
      m_re_q.delete();
      m_im_q.delete();
      m_hold   = 1'b0;
      m_bubble = 1'b0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold   = 1'b0;
        m_bubble = 1'b1;
      end
    end else if (m_bubble) begin
      m_bubble = 1'b0;
    end else if (in_valid) begin
      m_re_q.push_back(int'(in_real));
      m_im_q.push_back(int'(in_imag));
      if (m_re_q.size() == L) begin
        sr = 0;
        si = 0;
        foreach (m_re_q[k]) begin
          sr += m_re_q[k];
          si += m_im_q[k];
        end
        m_out_re = sr;
        m_out_im = si;
        m_hold   = 1'b1;
        m_re_q.delete();
        m_im_q.delete();
      end
    end
  endtask

  // Advance one clock, update the model, then compare the ports shortly
  // after the edge.
  task automatic cycle_check();
    @(posedge clk);
    model_tick();
    #1;
    check("in_ready",  longint'(in_ready),  longint'(!m_hold && !m_bubble));
    check("out_valid", longint'(out_valid), longint'(m_hold));
    check("out_real",  longint'(out_real),  longint'(m_out_re));
    check("out_imag",  longint'(out_imag),  longint'(m_out_im));
  endtask

  task automatic step(input bit v, input int re, input int im, input bit ordy, input bit fl);
    @(negedge clk);
    in_valid  = v;
    in_real   = re[2*W-1:0];
    in_imag   = im[2*W-1:0];
    out_ready = ordy;
    flush     = fl;
    cycle_check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rr, ri;
    model_reset();
    #3;
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_real",  longint'(out_real), 0);
    check("reset_out_imag",  longint'(out_imag), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", longint'(in_ready), 1);

    // Back-to-back products, result taken immediately, then the one-cycle bubble.
    step(1, 1, 2, 1, 0);
    step(1, 3, -4, 1, 0);
    step(1, 5, 6, 1, 0);
    step(1, 7, 8, 1, 0);
    check("b2b_valid", longint'(out_valid), 1);
    check("b2b_real",  longint'(out_real), 16);
    check("b2b_imag",  longint'(out_imag), 12);
    step(0, 0, 0, 1, 0);
    check("b2b_valid_drop", longint'(out_valid), 0);
    check("b2b_bubble",     longint'(in_ready), 0);
    step(0, 0, 0, 1, 0);
    check("b2b_ready_back", longint'(in_ready), 1);

    // Full-scale products must not wrap.
    for (int i = 0; i < L; i++) step(1, -32768, 32767, 0, 0);
    check("max_real", longint'(out_real), -131072);
    check("max_imag", longint'(out_imag), 131068);
    idle(2);

    // Result held while downstream stalls; inputs offered meanwhile are ignored.
    for (int i = 0; i < L; i++) step(1, 2, -1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 9, 9, 0, 0);
    check("stall_real",  longint'(out_real), 8);
    check("stall_imag",  longint'(out_imag), -4);
    check("stall_ready", longint'(in_ready), 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < L; i++) step(1, 1, 1, 0, 0);
    check("after_stall_real", longint'(out_real), 4);
    check("after_stall_imag", longint'(out_imag), 4);
    idle(2);

    // inValid toggling every other cycle; idle cycles do not advance the count.
    for (int i = 0; i < 2*L; i++) step(i % 2 == 0, 1, 1, 0, 0);
    check("gap_valid", longint'(out_valid), 1);
    check("gap_real",  longint'(out_real), 4);
    idle(2);

    // Flush discards the partial sum and the input offered in the same cycle.
    step(1, 100, 100, 1, 0);
    step(1, 100, 100, 1, 0);
    step(1, 50, 50, 1, 1);
    for (int i = 0; i < L; i++) step(1, 1, 1, 1, 0);
    check("flush_real", longint'(out_real), 4);
    check("flush_imag", longint'(out_imag), 4);
    idle(2);

    // Asynchronous reset in the middle of accumulation.
    for (int i = 0; i < 3; i++) step(1, 10, -10, 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", longint'(out_valid), 0);
    check("async_real",  longint'(out_real), 0);
    check("async_imag",  longint'(out_imag), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < L; i++) step(1, 2, 3, 1, 0);
    check("post_reset_real", longint'(out_real), 8);
    check("post_reset_imag", longint'(out_imag), 12);
    idle(2);

    // Random traffic, including occasional flushes and downstream stalls.
    for (int i = 0; i < 500; i++) begin
      rr = int'($urandom_range(0, 65535)) - 32768;
      ri = int'($urandom_range(0, 65535)) - 32768;
      step(($urandom % 10) < 7, rr, ri, ($urandom % 2) == 0, ($urandom % 40) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
